branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter DEPTH, default 4: outstanding-branch queue entries; must be a power of two, 2..16.
REQ-002 Parameter PC_W, default 8: branch PC width.
REQ-003 Parameter IDX_W, default 4: predictor table index width.
REQ-004 Parameter CNT_W, default 16: statistics counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pred_valid  in  1  predictor issues a prediction this cycle.
REQ-008 pred_pc  in  PC_W  PC of the predicted branch.
REQ-009 pred_index  in  IDX_W  table index used for the prediction.
REQ-010 pred_taken  in  1  predicted direction.
REQ-011 pred_ready  out  1  queue can accept a prediction.
REQ-012 res_valid  in  1  execute stage resolves the oldest outstanding branch.
REQ-013 res_taken  in  1  actual branch direction.
REQ-014 res_ready  out  1  an outstanding branch exists to resolve.
REQ-015 upd_valid  out  1  one-cycle training pulse to the predictor table.
REQ-016 upd_index  out  IDX_W  table index to train.
REQ-017 upd_taken  out  1  actual outcome to train with.
REQ-018 mispredict  out  1  one-cycle pulse: the resolved branch was mispredicted.
REQ-019 mispredict_pc  out  PC_W  PC of the mispredicted branch; held until the next mispredict.
REQ-020 occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.
REQ-021 total_cnt, mispred_cnt  out  CNT_W each  resolved-branch and mispredict counts.

Function
REQ-022 Push occurs when pred_valid && pred_ready; {pred_pc, pred_index, pred_taken} is written at the tail.
REQ-023 Pop occurs when res_valid && res_ready; the head entry is compared against res_taken.
REQ-024 FSM has two states: RUN and FLUSH; reset enters RUN.
REQ-025 In RUN: pred_ready = (occupancy < DEPTH); res_ready = (occupancy != 0).
REQ-026 In FLUSH: pred_ready = 0 and res_ready = 0; the FSM returns to RUN after exactly one cycle.
REQ-027 A pop with head.pred_taken != res_taken is a mispredict: clear the queue (occupancy 0, pointers equal), enter FLUSH, and discard any push in the same cycle.
REQ-028 A correct pop in the same cycle as a push leaves occupancy unchanged; the push is stored normally.
REQ-029 Full queue: pred_ready = 0 even if a pop occurs in the same cycle, so there is no bypass.
REQ-030 Empty queue: res_valid is ignored; no update and no counter change.
REQ-031 Every pop drives registered upd_valid=1, upd_index=head.pred_index, upd_taken=res_taken on the next cycle, for one cycle; latency is 1.
REQ-032 A mispredicting pop drives mispredict=1 and loads mispredict_pc=head.pred_pc on the next cycle.
REQ-033 total_cnt increments on every pop; mispred_cnt increments on every mispredict; both saturate at 2^CNT_W-1.
REQ-034 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Reset
REQ-035 Reset forces RUN state, pointers 0, occupancy 0, and upd_valid, upd_index, upd_taken, mispredict, mispredict_pc, total_cnt, mispred_cnt all 0.
REQ-036 Reset mid-operation discards all outstanding entries immediately; queue storage contents need not be reset.

Structure
REQ-037 A shared package bp_pkg holds PC_W, IDX_W, DEPTH defaults and the entry struct {pc, index, taken}.
REQ-038 Queue storage and pointers live in one sub-module, br_queue, with push, pop, clear, full and empty signals; the FSM, compare logic and counters live in branch_resolve.

Verification
REQ-039 Push pc=0x10/idx=3/T, then resolve T -> next cycle upd_valid=1, upd_index=3, upd_taken=1, mispredict=0; total_cnt=1.
REQ-040 Push 4 entries -> occupancy=4, pred_ready=0; a 5th pred_valid is dropped; pops return entries in order, with wrap verified over 10 pushes.
REQ-041 Push 3 entries, resolve the head with the wrong direction while pushing -> mispredict=1, mispredict_pc=head pc, occupancy=0, one FLUSH cycle with both readys 0, push lost.
REQ-042 Simultaneous push and correct pop at occupancy 2 -> occupancy stays 2; the next pops return the FIFO order.
REQ-043 Assert reset asynchronously with 3 entries queued -> occupancy=0, counters=0, upd_valid=0 without waiting for a clock edge.
REQ-044 Force mispred_cnt to 2^CNT_W-1, then mispredict -> count holds at 2^CNT_W-1, and res_valid on an empty queue leaves counts unchanged.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, FSM states and queue entry type for branch resolution
package bp_pkg;

    localparam int BP_DEPTH = 4;
    localparam int BP_PC_W  = 8;
    localparam int BP_IDX_W = 4;
    localparam int BP_CNT_W = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Entry layout at default widths; the queue stores it flattened as {pc, index, taken}.
    typedef struct packed {
        logic [BP_PC_W-1:0]  pc;
        logic [BP_IDX_W-1:0] index;
        logic                taken;
    } entry_t;

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - prediction, resolution, training and status signals
interface branch_resolve_if #(
    parameter int DEPTH = bp_pkg::BP_DEPTH,
    parameter int PC_W  = bp_pkg::BP_PC_W,
    parameter int IDX_W = bp_pkg::BP_IDX_W,
    parameter int CNT_W = bp_pkg::BP_CNT_W
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic [IDX_W-1:0] pred_index;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             mispredict;
    logic [PC_W-1:0]  mispredict_pc;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // Predictor / execute side
    modport master (
        output pred_valid, pred_pc, pred_index, pred_taken, res_valid, res_taken,
        input  pred_ready, res_ready, upd_valid, upd_index, upd_taken,
        input  mispredict, mispredict_pc, occupancy, total_cnt, mispred_cnt
    );

    // Resolution unit side
    modport slave (
        input  pred_valid, pred_pc, pred_index, pred_taken, res_valid, res_taken,
        output pred_ready, res_ready, upd_valid, upd_index, upd_taken,
        output mispredict, mispredict_pc, occupancy, total_cnt, mispred_cnt
    );

endinterface

// File: rtl/br_queue.sv
// rtl/br_queue.sv - outstanding-branch FIFO with clear, full/empty and occupancy
module br_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Next pointers/count: clear wins over everything; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted as valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - resolves queued branch predictions, trains predictor, counts mispredicts
module branch_resolve
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W,
    parameter int CNT_W = BP_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    branch_resolve_if.slave   bus
);
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = PC_W + IDX_W + 1;

    state_t             state_q, state_d;
    logic               q_full, q_empty;
    logic [OCC_W-1:0]   q_count;
    logic [ENTRY_W-1:0] head, wdata;
    logic [PC_W-1:0]    head_pc;
    logic [IDX_W-1:0]   head_index;
    logic               head_taken;
    logic               pred_ready, res_ready;
    logic               push, pop, mis_pop;

    logic               upd_valid_q;
    logic [IDX_W-1:0]   upd_index_q;
    logic               upd_taken_q;
    logic               mispredict_q;
    logic [PC_W-1:0]    mispredict_pc_q;
    logic [CNT_W-1:0]   total_cnt_q;
    logic [CNT_W-1:0]   mispred_cnt_q;

    assign head_pc    = head[ENTRY_W-1 -: PC_W];
    assign head_index = head[IDX_W:1];
    assign head_taken = head[0];
    assign wdata      = {bus.pred_pc, bus.pred_index, bus.pred_taken};

    // No full-queue bypass: a pop in the same cycle does not open a slot for a push.
    assign pred_ready = (state_q == ST_RUN) && !q_full;
    assign res_ready  = (state_q == ST_RUN) && !q_empty;
    assign pop        = bus.res_valid && res_ready;
    assign mis_pop    = pop && (head_taken != bus.res_taken);
    assign push       = bus.pred_valid && pred_ready && !mis_pop;

    br_queue #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (mis_pop),
        .wdata (wdata),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Next state: a mispredict costs exactly one FLUSH cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (mis_pop) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Training pulse, mispredict report and saturating statistics, all one cycle after the pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q     <= 1'b0;
            upd_index_q     <= '0;
            upd_taken_q     <= 1'b0;
            mispredict_q    <= 1'b0;
            mispredict_pc_q <= '0;
            total_cnt_q     <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            upd_valid_q  <= pop;
            mispredict_q <= mis_pop;
            if (pop) begin
                upd_index_q <= head_index;
                upd_taken_q <= bus.res_taken;
                if (total_cnt_q != '1) total_cnt_q <= total_cnt_q + CNT_W'(1);
            end
            if (mis_pop) begin
                mispredict_pc_q <= head_pc;
                if (mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pred_ready    = pred_ready;
    assign bus.res_ready     = res_ready;
    assign bus.upd_valid     = upd_valid_q;
    assign bus.upd_index     = upd_index_q;
    assign bus.upd_taken     = upd_taken_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.mispredict_pc = mispredict_pc_q;
    assign bus.occupancy     = q_count;
    assign bus.total_cnt     = total_cnt_q;
    assign bus.mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 8;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_if #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    branch_resolve #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int exp_total = 0;
    int exp_mis   = 0;
    entry_t ea, eb, ec, ed;
    entry_t fill [4];

    function automatic entry_t mk(input int pc, input int idx, input logic t);
        entry_t e;
        e.pc    = PC_W'(pc);
        e.index = IDX_W'(idx);
        e.taken = t;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input entry_t e, input logic rv, input logic rt);
        bus.pred_valid = pv;
        bus.pred_pc    = e.pc;
        bus.pred_index = e.index;
        bus.pred_taken = e.taken;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
    endtask

    task automatic push(input entry_t e);
        drive(1'b1, e, 1'b0, 1'b0);
    endtask

    task automatic bump_total();
        if (exp_total < MAXC) exp_total++;
    endtask

    // Correct resolution of the expected head entry.
    task automatic pop_ok(input string tag, input entry_t e);
        drive(1'b0, mk(0, 0, 1'b0), 1'b1, e.taken);
        bump_total();
        chk({tag, ".upd_valid"}, 32'(bus.upd_valid), 32'd1);
        chk({tag, ".upd_index"}, 32'(bus.upd_index), 32'(e.index));
        chk({tag, ".upd_taken"}, 32'(bus.upd_taken), 32'(e.taken));
        chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'd0);
        chk({tag, ".total_cnt"}, 32'(bus.total_cnt), 32'(exp_total));
    endtask

    // Wrong-direction resolution of head, optional same-cycle push, then the FLUSH cycle.
    task automatic mispred(input string tag, input entry_t head, input logic pv, input entry_t e);
        drive(pv, e, 1'b1, !head.taken);
        bump_total();
        if (exp_mis < MAXC) exp_mis++;
        chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'd1);
        chk({tag, ".mispredict_pc"}, 32'(bus.mispredict_pc), 32'(head.pc));
        chk({tag, ".occupancy"}, 32'(bus.occupancy), 32'd0);
        chk({tag, ".flush_pred_ready"}, 32'(bus.pred_ready), 32'd0);
        chk({tag, ".flush_res_ready"}, 32'(bus.res_ready), 32'd0);
        chk({tag, ".upd_valid"}, 32'(bus.upd_valid), 32'd1);
        chk({tag, ".upd_index"}, 32'(bus.upd_index), 32'(head.index));
        chk({tag, ".upd_taken"}, 32'(bus.upd_taken), 32'(!head.taken));
        chk({tag, ".mispred_cnt"}, 32'(bus.mispred_cnt), 32'(exp_mis));
        chk({tag, ".total_cnt"}, 32'(bus.total_cnt), 32'(exp_total));
        drive(1'b1, mk(8'h60, 9, 1'b1), 1'b1, 1'b0);
        chk({tag, ".post_mispredict"}, 32'(bus.mispredict), 32'd0);
        chk({tag, ".post_occupancy"}, 32'(bus.occupancy), 32'd0);
        chk({tag, ".post_pred_ready"}, 32'(bus.pred_ready), 32'd1);
        chk({tag, ".post_res_ready"}, 32'(bus.res_ready), 32'd0);
        chk({tag, ".post_upd_valid"}, 32'(bus.upd_valid), 32'd0);
        chk({tag, ".post_mispredict_pc"}, 32'(bus.mispredict_pc), 32'(head.pc));
        chk({tag, ".post_mispred_cnt"}, 32'(bus.mispred_cnt), 32'(exp_mis));
    endtask

    initial begin
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.pred_index = '0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;

        // Reset state
        #12;
        chk("rst.occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst.pred_ready", 32'(bus.pred_ready), 32'd1);
        chk("rst.res_ready", 32'(bus.res_ready), 32'd0);
        chk("rst.upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst.mispredict", 32'(bus.mispredict), 32'd0);
        chk("rst.mispredict_pc", 32'(bus.mispredict_pc), 32'd0);
        chk("rst.total_cnt", 32'(bus.total_cnt), 32'd0);
        chk("rst.mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single push then correct resolve
        push(mk(8'h10, 3, 1'b1));
        chk("basic.occupancy", 32'(bus.occupancy), 32'd1);
        chk("basic.res_ready", 32'(bus.res_ready), 32'd1);
        pop_ok("basic", mk(8'h10, 3, 1'b1));
        chk("basic.total_is_1", 32'(bus.total_cnt), 32'd1);
        drive(1'b0, mk(0, 0, 1'b0), 1'b1, 1'b1);
        chk("empty_res.upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("empty_res.total_cnt", 32'(bus.total_cnt), 32'd1);
        chk("empty_res.occupancy", 32'(bus.occupancy), 32'd0);

        // Fill to DEPTH, drop a fifth, drain in order
        for (int i = 0; i < 4; i++) begin
            fill[i] = mk(8'h20 + i, i, i[0]);
            push(fill[i]);
        end
        chk("full.occupancy", 32'(bus.occupancy), 32'd4);
        chk("full.pred_ready", 32'(bus.pred_ready), 32'd0);
        push(mk(8'h24, 7, 1'b1));
        chk("full.drop_occupancy", 32'(bus.occupancy), 32'd4);
        for (int i = 0; i < 4; i++) pop_ok("drain", fill[i]);
        chk("drain.occupancy", 32'(bus.occupancy), 32'd0);

        // Second fill across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            fill[i] = mk(8'h30 + i, 8 + i, !i[0]);
            push(fill[i]);
        end
        chk("wrap.occupancy", 32'(bus.occupancy), 32'd4);
        for (int i = 0; i < 4; i++) pop_ok("wrap", fill[i]);
        push(mk(8'h38, 12, 1'b1));
        pop_ok("wrap_tail0", mk(8'h38, 12, 1'b1));
        push(mk(8'h39, 13, 1'b0));
        pop_ok("wrap_tail1", mk(8'h39, 13, 1'b0));

        // Simultaneous push and correct pop at occupancy 2
        ea = mk(8'h40, 1, 1'b1);
        eb = mk(8'h41, 2, 1'b0);
        ec = mk(8'h42, 5, 1'b1);
        push(ea);
        push(eb);
        drive(1'b1, ec, 1'b1, ea.taken);
        bump_total();
        chk("pushpop.occupancy", 32'(bus.occupancy), 32'd2);
        chk("pushpop.upd_index", 32'(bus.upd_index), 32'(ea.index));
        chk("pushpop.total_cnt", 32'(bus.total_cnt), 32'(exp_total));
        pop_ok("pushpop_b", eb);
        pop_ok("pushpop_c", ec);

        // Mispredict with three queued and a push in the same cycle
        ed = mk(8'h50, 6, 1'b1);
        push(ed);
        push(mk(8'h51, 7, 1'b0));
        push(mk(8'h52, 8, 1'b1));
        chk("mis3.occupancy_before", 32'(bus.occupancy), 32'd3);
        mispred("mis3", ed, 1'b1, mk(8'h53, 10, 1'b0));

        // Drive mispred_cnt to saturation and beyond
        for (int i = 0; i < MAXC; i++) begin
            ea = mk(8'h70 + i, i, i[1]);
            push(ea);
            mispred("sat", ea, 1'b0, mk(0, 0, 1'b0));
        end
        chk("sat.mispred_cnt", 32'(bus.mispred_cnt), 32'(MAXC));
        chk("sat.total_cnt", 32'(bus.total_cnt), 32'(MAXC));
        drive(1'b0, mk(0, 0, 1'b0), 1'b1, 1'b0);
        chk("sat_empty.upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("sat_empty.mispred_cnt", 32'(bus.mispred_cnt), 32'(MAXC));
        chk("sat_empty.total_cnt", 32'(bus.total_cnt), 32'(MAXC));

        // Asynchronous reset mid-operation
        push(mk(8'h90, 1, 1'b1));
        push(mk(8'h91, 2, 1'b1));
        push(mk(8'h92, 3, 1'b1));
        drive(1'b0, mk(0, 0, 1'b0), 1'b1, 1'b1);
        chk("arst.pre_upd_valid", 32'(bus.upd_valid), 32'd1);
        chk("arst.pre_occupancy", 32'(bus.occupancy), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.occupancy", 32'(bus.occupancy), 32'd0);
        chk("arst.total_cnt", 32'(bus.total_cnt), 32'd0);
        chk("arst.mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        chk("arst.upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("arst.mispredict_pc", 32'(bus.mispredict_pc), 32'd0);
        chk("arst.res_ready", 32'(bus.res_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.post_occupancy", 32'(bus.occupancy), 32'd0);
        chk("arst.post_pred_ready", 32'(bus.pred_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
